// File: rtl/ioblock_bank.sv
// WIDTH-pin configurable I/O bank: serial shadow configuration chain with atomic
// commit, per-pin optional output/tristate/input registering and pad tristate drive.
module ioblock_bank #(
    parameter int WIDTH = 4
) (
    input  logic             IOCLK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] TS,
    input  logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] IN,
    input  logic             CFG_EN,
    input  logic             CFG_DIN,
    input  logic             CFG_LOAD,
    output logic             CFG_DOUT,
    output logic             CFG_DONE,
    output logic             CFG_ERR
);

    localparam int CFG_BITS = 4 * WIDTH;
    localparam int CW       = $clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    tsReg_q, outReg_q, dinReg_q;
    logic                full;

    assign full     = (count_q == CW'(CFG_BITS));
    assign CFG_DOUT = shadow_q[0];
    assign CFG_DONE = full;
    assign CFG_ERR  = err_q;

    // A load takes priority over a shift in the same cycle; the shift is dropped.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = 1'b0;
        if (CFG_LOAD) begin
            count_d = '0;
            if (full) begin
                active_d = shadow_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (CFG_EN) begin
            shadow_d = {CFG_DIN, shadow_q[CFG_BITS-1:1]};
            if (!full) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            tsReg_q  <= '0;
            outReg_q <= '0;
            dinReg_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
            tsReg_q  <= TS;
            outReg_q <= OUT;
            dinReg_q <= PIN;
        end
    end

    // Pin fields are {DOUTREG, DINREG, TSMUX[1:0]} in active_q[4i+3:4i].
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [1:0] tsMux;
        logic       doutReg, dinReg, effTs, effOut, drive;

        assign tsMux   = active_q[4*i +: 2];
        assign dinReg  = active_q[4*i + 2];
        assign doutReg = active_q[4*i + 3];
        assign effTs   = doutReg ? tsReg_q[i]  : TS[i];
        assign effOut  = doutReg ? outReg_q[i] : OUT[i];
        assign drive   = tsMux[1] | (tsMux[0] & effTs);
        assign PIN[i]  = drive ? effOut : 1'bz;
        assign IN[i]   = dinReg ? dinReg_q[i] : PIN[i];
    end

endmodule

// File: tb/tb_ioblock_bank.sv
// Self-checking bench for ioblock_bank: directed configuration scenarios followed by
// randomized traffic, all compared against a bit-queue/array reference model.
module tb_ioblock_bank;

    logic       IOCLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] TS = '0, OUT = '0;
    logic       CFG_EN = 1'b0, CFG_DIN = 1'b0, CFG_LOAD = 1'b0;
    wire  [3:0] PIN;
    logic [3:0] IN;
    logic       CFG_DOUT, CFG_DONE, CFG_ERR;
    logic [3:0] extEn = '0, extVal = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cfgM[4];
    bit         shadowQ[$];
    int         countM;
    bit         errM;
    bit         prevTs[4], prevOut[4], prevPin[4];
    logic [3:0] expPin, expIn, bankDrv;
    logic [3:0] tsV = '0, outV = '0, extV = '0;

    always #5 IOCLK = ~IOCLK;

    for (genvar g = 0; g < 4; g++) begin : g_ext
        assign PIN[g] = extEn[g] ? extVal[g] : 1'bz;
    end

    ioblock_bank #(.WIDTH(4)) dut (
        .IOCLK(IOCLK), .RST(RST), .PIN(PIN), .TS(TS), .OUT(OUT), .IN(IN),
        .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN), .CFG_LOAD(CFG_LOAD),
        .CFG_DOUT(CFG_DOUT), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) begin
            cfgM[i] = 0; prevTs[i] = 0; prevOut[i] = 0; prevPin[i] = 0;
        end
        shadowQ.delete();
        for (int k = 0; k < 16; k++) shadowQ.push_back(1'b0);
        countM = 0;
        errM = 0;
    endfunction

    function automatic void computeExpect();
        for (int i = 0; i < 4; i++) begin
            int  mux;
            bit  dReg, iReg, t, o, drv;
            mux  = cfgM[i] % 4;
            iReg = ((cfgM[i] / 4) % 2) == 1;
            dReg = ((cfgM[i] / 8) % 2) == 1;
            t    = dReg ? prevTs[i]  : TS[i];
            o    = dReg ? prevOut[i] : OUT[i];
            drv  = (mux >= 2) || (mux == 1 && t);
            bankDrv[i] = drv;
            expPin[i]  = drv ? o : extVal[i];
            expIn[i]   = iReg ? prevPin[i] : expPin[i];
        end
    endfunction

    function automatic void modelEdge();
        if (RST) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            prevTs[i] = TS[i]; prevOut[i] = OUT[i]; prevPin[i] = expPin[i];
        end
        errM = 0;
        if (CFG_LOAD) begin
            if (countM == 16) begin
                for (int i = 0; i < 4; i++)
                    cfgM[i] = shadowQ[4*i] + 2*shadowQ[4*i+1] + 4*shadowQ[4*i+2] + 8*shadowQ[4*i+3];
            end else begin
                errM = 1;
            end
            countM = 0;
        end else if (CFG_EN) begin
            shadowQ.push_back(CFG_DIN);
            void'(shadowQ.pop_front());
            if (countM < 16) countM++;
        end
    endfunction

    // One clock cycle: apply inputs, let the pads settle, compare, then clock.
    task automatic applyStimulus(input logic rst, input logic en, input logic din, input logic load);
        RST = rst; CFG_EN = en; CFG_DIN = din; CFG_LOAD = load;
        TS = tsV; OUT = outV; extVal = extV;
        computeExpect();
        extEn = ~bankDrv;
        #2;
        computeExpect();
        checkOutput("pin", 32'(PIN), 32'(expPin));
        checkOutput("in", 32'(IN), 32'(expIn));
        checkOutput("cfg_dout", 32'(CFG_DOUT), 32'(shadowQ[0]));
        checkOutput("cfg_done", 32'(CFG_DONE), 32'(countM == 16));
        checkOutput("cfg_err", 32'(CFG_ERR), 32'(errM));
        @(posedge IOCLK);
        modelEdge();
        #1;
    endtask

    task automatic shiftBits(input logic [15:0] word, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, word[k], 1'b0);
    endtask

    initial begin
        modelReset();
        RST = 1'b1;
        extEn = 4'hF; extVal = 4'hF;
        @(posedge IOCLK);
        #1;
        RST = 1'b0;

        // Reset with pads pulled high externally
        extV = 4'hF;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_in_all_ones", 32'(IN), 32'h0000000F);

        // Full load: pin3=A, pin2=6, pin1=1, pin0=2
        extV = 4'h0; tsV = 4'h0; outV = 4'h0;
        shiftBits(16'hA612, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        outV = 4'hF;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Short load leaves the active configuration alone
        shiftBits(16'h0000, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Registered input on pin2 (DINREG, Z) versus direct input on pin1
        shiftBits(16'h0400, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            extV = (k % 2 == 1) ? 4'hF : 4'h0;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Load and shift together after a full chain: shift is dropped
        shiftBits(16'h5A3C, 16);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-shift, then a fresh stream read back through CFG_DOUT
        shiftBits(16'h007F, 7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        shiftBits(16'hC92E, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        shiftBits(16'h0000, 16);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            tsV  = 4'($urandom);
            outV = 4'($urandom);
            extV = 4'($urandom);
            applyStimulus(($urandom % 200) == 0, ($urandom % 10) < 8,
                          1'($urandom), ($urandom % 25) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
